// File: rtl/bidin_if.sv
// Soft-bit deinterleaver bus: demodulator-side input stream and LDPC-side output stream.
interface bidin_if #(parameter int WID = 6);
  logic [1:0]     mode;
  logic           bidin_sync_in;
  logic           bidin_ena_in;
  logic [WID-1:0] bidin_din;
  logic           ldpc_req;
  logic           bidin_rdy;
  logic           bidin_full;
  logic           bidin_ovf;
  logic           bidin_ena_out;
  logic [WID-1:0] bidin_dout;
  logic           bidin_sof_out;
  logic           bidin_eof_out;

  modport master (
    output mode, bidin_sync_in, bidin_ena_in, bidin_din, ldpc_req,
    input  bidin_rdy, bidin_full, bidin_ovf, bidin_ena_out, bidin_dout,
           bidin_sof_out, bidin_eof_out
  );
  modport slave (
    input  mode, bidin_sync_in, bidin_ena_in, bidin_din, ldpc_req,
    output bidin_rdy, bidin_full, bidin_ovf, bidin_ena_out, bidin_dout,
           bidin_sof_out, bidin_eof_out
  );
endinterface

// File: rtl/bidin_pp.sv
// Ping-pong block deinterleaver: frames written column-major into one of two banks,
// drained row-major to the LDPC decoder from the other.
module bidin_pp #(
  parameter int WID      = 6,
  parameter int ROW_UNIT = 72,
  parameter int COLS     = 240,
  parameter int AW       = 17
) (
  input logic clk,
  input logic rst,
  bidin_if.slave bus
);
  localparam int RMAX = 3 * ROW_UNIT;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int CW   = $clog2(COLS + 1);
  localparam int LW   = $clog2(RMAX * COLS + 1);

  localparam logic [1:0] W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0, R_READ = 1'b1;

  function automatic logic [RW-1:0] r_of(input logic [1:0] m);
    case (m)
      2'd2:    r_of = RW'(2 * ROW_UNIT);
      2'd3:    r_of = RW'(3 * ROW_UNIT);
      default: r_of = RW'(ROW_UNIT);
    endcase
  endfunction

  logic [WID-1:0] mem [0:(2**(AW+1))-1];

  logic [1:0]         full;
  logic [1:0][RW-1:0] bank_r;

  logic [1:0]    ws;
  logic          wb, ovf;
  logic [RW-1:0] wr_r, row;
  logic [CW-1:0] col;
  logic [AW-1:0] wptr;

  logic [0:0]    rs;
  logic          rb;
  logic [LW-1:0] raddr;
  logic          ena_out, sof_out, eof_out;
  logic [WID-1:0] dout;

  // Effective write context: a sync restarts the frame in the same cycle so that a
  // coincident sample lands at index 0 of the new frame.
  logic [1:0]    c_st;
  logic [RW-1:0] c_r, c_row;
  logic [CW-1:0] c_col;
  logic [AW-1:0] c_addr;
  logic          smp, row_wrap, w_last, we;

  always_comb begin
    c_st   = ws;
    c_r    = wr_r;
    c_row  = row;
    c_col  = col;
    c_addr = wptr;
    if (bus.bidin_sync_in) begin
      c_st   = full[wb] ? W_DROP : W_FILL;
      c_r    = r_of(bus.mode);
      c_row  = '0;
      c_col  = '0;
      c_addr = '0;
    end
  end

  assign smp      = bus.bidin_ena_in && (c_st != W_IDLE);
  assign row_wrap = (c_row == RW'(c_r - RW'(1)));
  assign w_last   = row_wrap && (c_col == CW'(COLS - 1));
  assign we       = smp && (c_st == W_FILL);

  logic          rdy, rd_en, r_last;
  logic [LW-1:0] rd_len;

  assign rdy    = (rs == R_IDLE) && full[rb];
  assign rd_en  = (rs == R_READ);
  assign rd_len = LW'(bank_r[rb]) * LW'(COLS);
  assign r_last = (raddr == LW'(rd_len - LW'(1)));

  always_ff @(posedge clk) begin
    if (we) mem[{wb, c_addr}] <= bus.bidin_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      bank_r  <= '0;
      ws      <= W_IDLE;
      wb      <= 1'b0;
      ovf     <= 1'b0;
      wr_r    <= '0;
      row     <= '0;
      col     <= '0;
      wptr    <= '0;
      rs      <= R_IDLE;
      rb      <= 1'b0;
      raddr   <= '0;
      ena_out <= 1'b0;
      sof_out <= 1'b0;
      eof_out <= 1'b0;
      dout    <= '0;
    end else begin
      ws   <= c_st;
      wr_r <= c_r;
      row  <= c_row;
      col  <= c_col;
      wptr <= c_addr;
      if (bus.bidin_sync_in) ovf <= full[wb];
      if (smp) begin
        if (w_last) begin
          ws  <= W_IDLE;
          ovf <= 1'b0;
          if (c_st == W_FILL) wb <= ~wb;
        end else if (row_wrap) begin
          row  <= '0;
          col  <= c_col + CW'(1);
          wptr <= AW'(c_col) + AW'(1);
        end else begin
          row  <= c_row + RW'(1);
          wptr <= c_addr + AW'(COLS);
        end
      end

      if (bus.ldpc_req && rdy) begin
        rs    <= R_READ;
        raddr <= '0;
      end
      if (rd_en) begin
        raddr <= raddr + LW'(1);
        dout  <= mem[{rb, AW'(raddr)}];
        if (r_last) begin
          rs <= R_IDLE;
          rb <= ~rb;
        end
      end
      ena_out <= rd_en;
      sof_out <= rd_en && (raddr == '0);
      eof_out <= rd_en && r_last;

      // Write-complete and read-release always hit different banks, so both apply.
      for (int b = 0; b < 2; b++) begin
        if (we && w_last && (wb == 1'(b))) begin
          full[b]   <= 1'b1;
          bank_r[b] <= c_r;
        end
        if (rd_en && r_last && (rb == 1'(b))) full[b] <= 1'b0;
      end
    end
  end

  assign bus.bidin_rdy     = rdy;
  assign bus.bidin_full    = &full;
  assign bus.bidin_ovf     = ovf;
  assign bus.bidin_ena_out = ena_out;
  assign bus.bidin_dout    = dout;
  assign bus.bidin_sof_out = sof_out;
  assign bus.bidin_eof_out = eof_out;
endmodule

// File: tb/tb_bidin_pp.sv
// Scoreboard bench for bidin_pp with ROW_UNIT=2, COLS=3 and hand-computed row-major orders.
module tb_bidin_pp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bidin_if #(.WID(8)) bus();

  bidin_pp #(.WID(8), .ROW_UNIT(2), .COLS(3), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   v[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.bidin_ena_out === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got dout=%0d with no expected sample", bus.bidin_dout);
      end else begin
        e = q.pop_front();
        if ({bus.bidin_dout, bus.bidin_sof_out, bus.bidin_eof_out} !== {e.d, e.sof, e.eof}) begin
          n_bad++;
          $display("FAIL out_sample: got d=%0d sof=%0b eof=%0b expected d=%0d sof=%0b eof=%0b",
                   bus.bidin_dout, bus.bidin_sof_out, bus.bidin_eof_out, e.d, e.sof, e.eof);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.mode          = 2'd1;
    bus.bidin_sync_in = 1'b0;
    bus.bidin_ena_in  = 1'b0;
    bus.bidin_din     = '0;
    bus.ldpc_req      = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.mode          = m;
      bus.bidin_sync_in = (i == 0);
      bus.bidin_ena_in  = 1'b1;
      bus.bidin_din     = 8'(base + i);
      tick();
    end
    bus.bidin_sync_in = 1'b0;
    bus.bidin_ena_in  = 1'b0;
  endtask

  task automatic exp_frame(input int n, input int vals[12]);
    for (int i = 0; i < n; i++) q.push_back('{d: 8'(vals[i]), sof: (i == 0), eof: (i == n - 1)});
  endtask

  task automatic rd(input int n);
    bus.ldpc_req = 1'b1;
    tick();
    bus.ldpc_req = 1'b0;
    repeat (n + 3) tick();
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_rdy",  bus.bidin_rdy,     0);
    chk("rst_full", bus.bidin_full,    0);
    chk("rst_ovf",  bus.bidin_ovf,     0);
    chk("rst_ena",  bus.bidin_ena_out, 0);
    chk("rst_dout", bus.bidin_dout,    0);
    rst = 1'b0;
    tick();

    // mode 1, latency of first output
    send(2'd1, 0, 5);
    chk("rdy_before_last", bus.bidin_rdy, 0);
    bus.bidin_sync_in = 1'b0; bus.bidin_ena_in = 1'b1; bus.bidin_din = 8'd5;
    tick();
    bus.bidin_ena_in = 1'b0;
    chk("rdy_after_frame", bus.bidin_rdy, 1);
    v = '{0, 2, 4, 1, 3, 5, 0, 0, 0, 0, 0, 0};
    exp_frame(6, v);
    bus.ldpc_req = 1'b1;
    tick();
    bus.ldpc_req = 1'b0;
    chk("ena_t1", bus.bidin_ena_out, 0);
    tick();
    chk("ena_t2", bus.bidin_ena_out, 1);
    repeat (7) tick();
    chk("rdy_after_read", bus.bidin_rdy, 0);

    // mode 2
    send(2'd2, 0, 12);
    v = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    exp_frame(12, v);
    rd(12);

    // mode 0 behaves as mode 1
    send(2'd0, 20, 6);
    v = '{20, 22, 24, 21, 23, 25, 0, 0, 0, 0, 0, 0};
    exp_frame(6, v);
    rd(6);

    // both banks full, third frame dropped
    send(2'd1, 30, 6);
    send(2'd1, 40, 6);
    chk("full_both", bus.bidin_full, 1);
    chk("rdy_both",  bus.bidin_rdy,  1);
    for (int i = 0; i < 6; i++) begin
      bus.bidin_sync_in = (i == 0);
      bus.bidin_ena_in  = 1'b1;
      bus.bidin_din     = 8'(50 + i);
      tick();
      chk("ovf_drop", bus.bidin_ovf, (i < 5) ? 1 : 0);
    end
    bus.bidin_sync_in = 1'b0;
    bus.bidin_ena_in  = 1'b0;
    v = '{30, 32, 34, 31, 33, 35, 0, 0, 0, 0, 0, 0};
    exp_frame(6, v);
    rd(6);
    chk("full_after_one_read", bus.bidin_full, 0);
    v = '{40, 42, 44, 41, 43, 45, 0, 0, 0, 0, 0, 0};
    exp_frame(6, v);
    rd(6);

    // partial frame discarded by resync
    send(2'd1, 60, 3);
    chk("rdy_partial", bus.bidin_rdy, 0);
    send(2'd1, 10, 6);
    v = '{10, 12, 14, 11, 13, 15, 0, 0, 0, 0, 0, 0};
    exp_frame(6, v);
    rd(6);

    // write completes in the cycle the read issues its last address
    send(2'd1, 70, 6);
    v = '{70, 72, 74, 71, 73, 75, 0, 0, 0, 0, 0, 0};
    exp_frame(6, v);
    v = '{80, 82, 84, 81, 83, 85, 0, 0, 0, 0, 0, 0};
    exp_frame(6, v);
    bus.ldpc_req = 1'b1;
    tick();
    bus.ldpc_req = 1'b0;
    send(2'd1, 80, 6);
    chk("rdy_overlap", bus.bidin_rdy, 1);
    rd(6);

    // reset in the middle of a read
    send(2'd1, 90, 6);
    send(2'd1, 100, 6);
    q.push_back('{d: 8'd90, sof: 1'b1, eof: 1'b0});
    bus.ldpc_req = 1'b1;
    tick();
    bus.ldpc_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ena",  bus.bidin_ena_out, 0);
    chk("mid_rst_rdy",  bus.bidin_rdy,     0);
    chk("mid_rst_full", bus.bidin_full,    0);
    chk("mid_rst_ovf",  bus.bidin_ovf,     0);
    chk("mid_rst_dout", bus.bidin_dout,    0);
    rst = 1'b0;
    tick();
    bus.ldpc_req = 1'b1;
    tick();
    bus.ldpc_req = 1'b0;
    repeat (5) tick();
    chk("post_rst_rdy", bus.bidin_rdy,     0);
    chk("post_rst_ena", bus.bidin_ena_out, 0);
    chk("queue_empty",  q.size(),          0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
